// File: rtl/matrix_stream_io.sv
// matrix_stream_io
// Streaming wrapper around the combinational Strassen matrix_mul array.
// Input elements arrive over a valid/ready handshake: first all of matrix A,
// then all of matrix B, each in row-major order. They are packed into the
// operand buses. After a settle window the product is registered and then
// streamed out row-major. Only one job is in flight at a time.
//
// Ports
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid/in_ready   : input element handshake
//   in_data [31:0]      : input element (A first, then B)
//   mat_a, mat_b        : packed operands to matrix_mul ([0][0] at the MSB end)
//   mat_result          : product from matrix_mul
//   out_valid/out_ready : output element handshake
//   out_data [31:0]     : result element
//   out_last            : out_data is the final element of the result
//   busy                : job in COMPUTE or DRAIN
module matrix_stream_io #(
    parameter int WIDTH_BIT   = 1,
    parameter int WIDTH       = 2 ** WIDTH_BIT,
    parameter int COMP_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_data,
    output logic [WIDTH*WIDTH*32-1:0]    mat_a,
    output logic [WIDTH*WIDTH*32-1:0]    mat_b,
    input  logic [WIDTH*WIDTH*32-1:0]    mat_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    output logic                         out_last,
    output logic                         busy
);

    localparam int NN = WIDTH * WIDTH;
    localparam int KW = (NN > 1) ? $clog2(NN) : 1;
    localparam int CW = (COMP_CYCLES > 1) ? $clog2(COMP_CYCLES) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(NN - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(COMP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'd0,
        S_LOAD_B  = 2'd1,
        S_COMPUTE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NN*32-1:0]    a_q, b_q, r_q;
    logic                a_we_s, b_we_s, r_we_s;
    logic [31:0]         out_data_s;

    // Next-state, element index, settle counter and register write enables.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        a_we_s  = 1'b0;
        b_we_s  = 1'b0;
        r_we_s  = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                if (in_valid) begin
                    a_we_s = 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = S_LOAD_B;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end
            S_LOAD_B: begin
                if (in_valid) begin
                    b_we_s = 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        cnt_d   = CNT_INIT;
                        state_d = S_COMPUTE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end
            S_COMPUTE: begin
                // Operands have been stable for COMP_CYCLES cycles once the counter reads zero.
                if (cnt_q == '0) begin
                    r_we_s  = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = S_LOAD_A;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end
            default: begin
                state_d = S_LOAD_A;
                k_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and operand/result storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOAD_A;
            k_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            // Element k lives at word NN-1-k so that [0][0] lands at the MSB end.
            for (int e = 0; e < NN; e++) begin
                if (a_we_s && (k_q == KW'(e))) begin
                    a_q[(NN-1-e)*32 +: 32] <= in_data;
                end
                if (b_we_s && (k_q == KW'(e))) begin
                    b_q[(NN-1-e)*32 +: 32] <= in_data;
                end
            end
            if (r_we_s) begin
                r_q <= mat_result;
            end
        end
    end

    // Result element select; one-hot OR mux over the stored product.
    always_comb begin
        out_data_s = 32'd0;
        for (int e = 0; e < NN; e++) begin
            out_data_s = out_data_s | ((k_q == KW'(e)) ? r_q[(NN-1-e)*32 +: 32] : 32'd0);
        end
    end

    // in_ready is gated with rst_n so nothing is offered while reset is held.
    assign in_ready  = rst_n & ((state_q == S_LOAD_A) | (state_q == S_LOAD_B));
    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = (state_q == S_DRAIN) & (k_q == K_LAST);
    assign busy      = (state_q == S_COMPUTE) | (state_q == S_DRAIN);
    assign out_data  = out_data_s;
    assign mat_a     = a_q;
    assign mat_b     = b_q;

endmodule

// File: tb/tb_matrix_stream_io.sv
// Directed testbench for matrix_stream_io. Three instances share one clock
// and reset: WIDTH=2/COMP_CYCLES=1 (dut_a), WIDTH=2/COMP_CYCLES=4 (dut_c)
// and WIDTH=1/COMP_CYCLES=1 (dut_s). The bench supplies the multiplier.
module tb_matrix_stream_io;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a;
    logic [31:0]  in_data_a, out_data_a;
    logic [127:0] mat_a_a, mat_b_a, mat_res_a;

    logic         in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_last_c, busy_c;
    logic [31:0]  in_data_c, out_data_c;
    logic [127:0] mat_a_c, mat_b_c, mat_res_c;

    logic         in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_last_s, busy_s;
    logic [31:0]  in_data_s, out_data_s;
    logic [31:0]  mat_a_s, mat_b_s, mat_res_s;

    // 2x2 multiplier stand-in, 32-bit wrap-around.
    function automatic logic [127:0] mm2(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        logic [31:0]  s;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 32'd0;
                for (int m = 0; m < 2; m++) begin
                    s = s + a[(3-(i*2+m))*32 +: 32] * b[(3-(m*2+j))*32 +: 32];
                end
                r[(3-(i*2+j))*32 +: 32] = s;
            end
        end
        return r;
    endfunction

    assign mat_res_a = mm2(mat_a_a, mat_b_a);
    assign mat_res_c = mm2(mat_a_c, mat_b_c);
    assign mat_res_s = mat_a_s * mat_b_s;

    matrix_stream_io #(.WIDTH(2), .COMP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .mat_a(mat_a_a), .mat_b(mat_b_a), .mat_result(mat_res_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_last(out_last_a), .busy(busy_a));

    matrix_stream_io #(.WIDTH(2), .COMP_CYCLES(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_data(in_data_c), .mat_a(mat_a_c), .mat_b(mat_b_c), .mat_result(mat_res_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
        .out_last(out_last_c), .busy(busy_c));

    matrix_stream_io #(.WIDTH(1), .COMP_CYCLES(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_data(in_data_s), .mat_a(mat_a_s), .mat_b(mat_b_s), .mat_result(mat_res_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
        .out_last(out_last_s), .busy(busy_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams A then B (8 words, first word at the MSB end) into dut_a.
    task automatic load_a(input logic [255:0] v);
        for (int i = 0; i < 8; i++) begin
            in_valid_a = 1'b1;
            in_data_a  = v[(7-i)*32 +: 32];
            tick();
        end
        in_valid_a = 1'b0;
        in_data_a  = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_a); end
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a); end
        n_checks++; if (busy_a !== 1'b0 || out_last_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_last: got %b%b expected 00", busy_a, out_last_a); end
        n_checks++; if (out_data_a !== 32'd0 || mat_a_a !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h %h expected zero", out_data_a, mat_a_a); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready_a !== 1'b1 || in_ready_c !== 1'b1 || in_ready_s !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b%b%b expected 111", in_ready_a, in_ready_c, in_ready_s); end
    endtask

    task automatic test_basic();
        logic [127:0] exp;
        exp = {32'd19, 32'd22, 32'd43, 32'd50};
        load_a({32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
        n_checks++; if (out_valid_a !== 1'b0 || busy_a !== 1'b1 || in_ready_a !== 1'b0) begin n_fail++; $display("FAIL basic_compute: got v=%b busy=%b rdy=%b expected 0 1 0", out_valid_a, busy_a, in_ready_a); end
        tick();
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b expected 1", out_valid_a); end
        n_checks++; if (mat_a_a !== {32'd1, 32'd2, 32'd3, 32'd4}) begin n_fail++; $display("FAIL basic_mat_a: got %h expected 00000001000000020000000300000004", mat_a_a); end
        n_checks++; if (mat_b_a !== {32'd5, 32'd6, 32'd7, 32'd8}) begin n_fail++; $display("FAIL basic_mat_b: got %h expected 00000005000000060000000700000008", mat_b_a); end
        out_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_data_a !== exp[(3-i)*32 +: 32]) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, out_data_a, exp[(3-i)*32 +: 32]); end
            n_checks++; if (out_last_a !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b expected %b", i, out_last_a, (i == 3)); end
            tick();
        end
        out_ready_a = 1'b0;
        n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_return: got rdy=%b v=%b expected 1 0", in_ready_a, out_valid_a); end
    endtask

    task automatic test_stall();
        logic [255:0] v;
        logic [127:0] exp;
        logic         acc, stalled;
        int           idx, j, cyc;
        v       = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        exp     = {32'd19, 32'd22, 32'd43, 32'd50};
        idx     = 0;
        cyc     = 0;
        while (idx < 8 && cyc < 100) begin
            in_valid_a = (cyc % 2 == 0);
            in_data_a  = in_valid_a ? v[(7-idx)*32 +: 32] : 32'hDEADBEEF;
            acc        = in_valid_a & in_ready_a;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid_a = 1'b0;
        n_checks++; if (idx !== 8) begin n_fail++; $display("FAIL stall_load_count: got %0d expected 8", idx); end
        j       = 0;
        cyc     = 0;
        stalled = 1'b0;
        while (j < 4 && cyc < 100) begin
            out_ready_a = (cyc % 3 == 2);
            if (stalled) begin
                n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL stall_valid_hold[%0d]: got %b expected 1", j, out_valid_a); end
            end
            if (out_valid_a) begin
                n_checks++; if (out_data_a !== exp[(3-j)*32 +: 32]) begin n_fail++; $display("FAIL stall_data[%0d]: got %0d expected %0d", j, out_data_a, exp[(3-j)*32 +: 32]); end
                n_checks++; if (out_last_a !== (j == 3)) begin n_fail++; $display("FAIL stall_last[%0d]: got %b expected %b", j, out_last_a, (j == 3)); end
            end
            acc     = out_valid_a & out_ready_a;
            stalled = out_valid_a & ~out_ready_a;
            tick();
            if (acc) j++;
            cyc++;
        end
        out_ready_a = 1'b0;
        n_checks++; if (j !== 4) begin n_fail++; $display("FAIL stall_out_count: got %0d expected 4", j); end
        n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL stall_done: got v=%b rdy=%b expected 0 1", out_valid_a, in_ready_a); end
    endtask

    task automatic test_wrap();
        logic [127:0] exp;
        exp = {32'hFFFFFFFE, 32'h0, 32'h0, 32'hFFFFFFFF};
        load_a({32'h7FFFFFFF, 32'h0, 32'h0, 32'h1, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF});
        n_checks++; if (mat_a_a !== 128'h7FFFFFFF_00000000_00000000_00000001) begin n_fail++; $display("FAIL wrap_mat_a: got %h expected 7fffffff000000000000000000000001", mat_a_a); end
        tick();
        out_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_data_a !== exp[(3-i)*32 +: 32]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, out_data_a, exp[(3-i)*32 +: 32]); end
            tick();
        end
        out_ready_a = 1'b0;
    endtask

    task automatic test_settle();
        logic [255:0] v;
        logic [127:0] exp;
        v   = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        exp = {32'd19, 32'd22, 32'd43, 32'd50};
        for (int i = 0; i < 8; i++) begin
            in_valid_c = 1'b1;
            in_data_c  = v[(7-i)*32 +: 32];
            tick();
        end
        in_data_c = 32'hBAD0BAD0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++; if (in_ready_c !== 1'b0 || busy_c !== 1'b1 || out_valid_c !== 1'b0) begin n_fail++; $display("FAIL settle_cycle[%0d]: got rdy=%b busy=%b v=%b expected 0 1 0", c, in_ready_c, busy_c, out_valid_c); end
            tick();
        end
        n_checks++; if (out_valid_c !== 1'b1) begin n_fail++; $display("FAIL settle_valid: got %b expected 1", out_valid_c); end
        n_checks++; if (mat_a_c !== v[255:128] || mat_b_c !== v[127:0]) begin n_fail++; $display("FAIL settle_operands: got %h %h expected %h", mat_a_c, mat_b_c, v); end
        out_ready_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_data_c !== exp[(3-i)*32 +: 32]) begin n_fail++; $display("FAIL settle_data[%0d]: got %0d expected %0d", i, out_data_c, exp[(3-i)*32 +: 32]); end
            n_checks++; if (out_last_c !== (i == 3)) begin n_fail++; $display("FAIL settle_last[%0d]: got %b expected %b", i, out_last_c, (i == 3)); end
            tick();
        end
        out_ready_c = 1'b0;
        in_valid_c  = 1'b0;
        n_checks++; if (in_ready_c !== 1'b1 || busy_c !== 1'b0 || mat_a_c !== v[255:128]) begin n_fail++; $display("FAIL settle_done: got rdy=%b busy=%b a=%h expected 1 0 %h", in_ready_c, busy_c, mat_a_c, v[255:128]); end
    endtask

    task automatic test_mid_reset();
        logic [127:0] exp;
        load_a({32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
        tick();
        out_ready_a = 1'b1;
        n_checks++; if (out_data_a !== 32'd19) begin n_fail++; $display("FAIL midrst_data0: got %0d expected 19", out_data_a); end
        tick();
        n_checks++; if (out_data_a !== 32'd22) begin n_fail++; $display("FAIL midrst_data1: got %0d expected 22", out_data_a); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        out_ready_a = 1'b0;
        #1;
        n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL midrst_state: got v=%b rdy=%b expected 0 1", out_valid_a, in_ready_a); end
        n_checks++; if (mat_a_a !== 128'd0 || mat_b_a !== 128'd0 || out_data_a !== 32'd0) begin n_fail++; $display("FAIL midrst_regs: got %h %h %h expected zero", mat_a_a, mat_b_a, out_data_a); end
        n_checks++; if (busy_a !== 1'b0 || out_last_a !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got busy=%b last=%b expected 0 0", busy_a, out_last_a); end
        exp = {32'd2, 32'd4, 32'd6, 32'd8};
        load_a({32'd2, 32'd0, 32'd0, 32'd2, 32'd1, 32'd2, 32'd3, 32'd4});
        tick();
        out_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_data_a !== exp[(3-i)*32 +: 32]) begin n_fail++; $display("FAIL midrst_fresh[%0d]: got %0d expected %0d", i, out_data_a, exp[(3-i)*32 +: 32]); end
            tick();
        end
        out_ready_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        in_valid_s = 1'b1;
        in_data_s  = 32'hFFFFFFFD;
        tick();
        in_data_s  = 32'd7;
        tick();
        in_valid_s = 1'b0;
        n_checks++; if (out_valid_s !== 1'b0 || busy_s !== 1'b1) begin n_fail++; $display("FAIL w1_compute: got v=%b busy=%b expected 0 1", out_valid_s, busy_s); end
        tick();
        n_checks++; if (out_valid_s !== 1'b1 || out_last_s !== 1'b1) begin n_fail++; $display("FAIL w1_valid_last: got %b%b expected 11", out_valid_s, out_last_s); end
        n_checks++; if (out_data_s !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL w1_data: got %h expected ffffffeb", out_data_s); end
        n_checks++; if (mat_a_s !== 32'hFFFFFFFD || mat_b_s !== 32'd7) begin n_fail++; $display("FAIL w1_operands: got %h %h expected fffffffd 00000007", mat_a_s, mat_b_s); end
        out_ready_s = 1'b1;
        in_valid_s  = 1'b1;
        in_data_s   = 32'd5;
        tick();
        out_ready_s = 1'b0;
        n_checks++; if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0) begin n_fail++; $display("FAIL w1_turnaround: got rdy=%b v=%b expected 1 0", in_ready_s, out_valid_s); end
        n_checks++; if (mat_a_s !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL w1_no_consume_in_drain: got %h expected fffffffd", mat_a_s); end
        tick();
        n_checks++; if (mat_a_s !== 32'd5) begin n_fail++; $display("FAIL w1_second_a: got %h expected 00000005", mat_a_s); end
        in_data_s = 32'hFFFFFFFC;
        tick();
        in_valid_s = 1'b0;
        tick();
        n_checks++; if (out_valid_s !== 1'b1 || out_data_s !== 32'hFFFFFFEC || out_last_s !== 1'b1) begin n_fail++; $display("FAIL w1_second_out: got v=%b d=%h l=%b expected 1 ffffffec 1", out_valid_s, out_data_s, out_last_s); end
        out_ready_s = 1'b1;
        tick();
        out_ready_s = 1'b0;
        n_checks++; if (in_ready_s !== 1'b1 || busy_s !== 1'b0) begin n_fail++; $display("FAIL w1_done: got rdy=%b busy=%b expected 1 0", in_ready_s, busy_s); end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid_a  = 1'b0; in_data_a = 32'd0; out_ready_a = 1'b0;
        in_valid_c  = 1'b0; in_data_c = 32'd0; out_ready_c = 1'b0;
        in_valid_s  = 1'b0; in_data_s = 32'd0; out_ready_s = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_settle();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
